// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if - EX-stage request/response bundle for the multiply/divide unit.
// master drives valid/aluop/operands/flush/hold; slave returns stall and HI/LO.
interface mdu_ctrl_if;
   logic        valid_i;
   logic [7:0]  aluop_i;
   logic [31:0] src_a_i;
   logic [31:0] src_b_i;
   logic        flush_i;
   logic        ex_hold_i;
   logic        stall_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport master (
      output valid_i, aluop_i, src_a_i, src_b_i,
      output flush_i, ex_hold_i,
      input  stall_o, hi_o, lo_o
   );

   modport slave (
      input  valid_i, aluop_i, src_a_i, src_b_i,
      input  flush_i, ex_hold_i,
      output stall_o, hi_o, lo_o
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl - EX-stage multiply/divide controller owning HI/LO; stalls while busy.
// Ports: clk, resetn (async, active-low), mdu (mdu_ctrl_if.slave: valid, aluop,
// src_a, src_b, flush, ex_hold in; stall, hi, lo out). Parameter MUL_LAT (1-8).
// Optional macro MDU_DIV_ZERO_FAST_EN: divide by zero finishes at once, no write.
module mdu_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic      clk,
   input  logic      resetn,
   mdu_ctrl_if.slave mdu
);
   localparam logic [7:0] ALUOP_MULT  = 8'h18;
   localparam logic [7:0] ALUOP_MULTU = 8'h19;
   localparam logic [7:0] ALUOP_DIV   = 8'h1A;
   localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
   localparam logic [7:0] ALUOP_MTHI  = 8'h11;
   localparam logic [7:0] ALUOP_MTLO  = 8'h13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIN
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   // Result pair; during DIV these are the remainder/quotient work registers.
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic        sgn_q, sgn_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        nowr_q, nowr_d;

   logic is_mul, is_div, is_sgn, is_mthi, is_mtlo;
   logic start, mt_ok, fast_zero;

   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_sgn  = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      unique case (1'b1)
         mdu.aluop_i == ALUOP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
         mdu.aluop_i == ALUOP_MULTU: is_mul = 1'b1;
         mdu.aluop_i == ALUOP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
         mdu.aluop_i == ALUOP_DIVU:  is_div = 1'b1;
         mdu.aluop_i == ALUOP_MTHI:  is_mthi = 1'b1;
         mdu.aluop_i == ALUOP_MTLO:  is_mtlo = 1'b1;
         default: ;
      endcase
   end

   assign start = resetn & (state_q == S_IDLE) & mdu.valid_i
                & ~mdu.flush_i & (is_mul | is_div);
   assign mt_ok = (state_q == S_IDLE) & mdu.valid_i
                & ~mdu.flush_i & ~mdu.ex_hold_i;

`ifdef MDU_DIV_ZERO_FAST_EN
   assign fast_zero = (mdu.src_b_i == 32'd0);
`else
   assign fast_zero = 1'b0;
`endif

   // One multiplier: fed straight from the operands when MUL_LAT=1 finishes
   // in the accept cycle, otherwise from the latched copies.
   logic [31:0] mul_a, mul_b;
   logic        mul_sgn;
   logic [63:0] ext_a, ext_b, prod;
   assign mul_a   = (state_q == S_IDLE) ? mdu.src_a_i : op_a_q;
   assign mul_b   = (state_q == S_IDLE) ? mdu.src_b_i : op_b_q;
   assign mul_sgn = (state_q == S_IDLE) ? is_sgn : sgn_q;
   assign ext_a   = {{32{mul_sgn & mul_a[31]}}, mul_a};
   assign ext_b   = {{32{mul_sgn & mul_b[31]}}, mul_b};
   assign prod    = ext_a * ext_b;

   logic [31:0] abs_a, abs_b;
   assign abs_a = (is_sgn & mdu.src_a_i[31]) ? -mdu.src_a_i : mdu.src_a_i;
   assign abs_b = (is_sgn & mdu.src_b_i[31]) ? -mdu.src_b_i : mdu.src_b_i;

   // Restoring step; one guard bit so a zero divisor never looks like a borrow.
   logic [32:0] shl;
   logic [33:0] trial;
   logic        ge;
   logic [31:0] step_rem, step_quo;
   assign shl      = {res_hi_q, res_lo_q[31]};
   assign trial    = {1'b0, shl} - {2'b00, op_b_q};
   assign ge       = ~trial[33];
   assign step_rem = ge ? trial[31:0] : shl[31:0];
   assign step_quo = {res_lo_q[30:0], ge};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      sgn_d    = sgn_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      nowr_d   = nowr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && is_mul) begin
               op_a_d = mdu.src_a_i;
               op_b_d = mdu.src_b_i;
               sgn_d  = is_sgn;
               nowr_d = 1'b0;
               cnt_d  = 5'(MUL_LAT - 1);
               if (MUL_LAT == 1) begin
                  res_hi_d = prod[63:32];
                  res_lo_d = prod[31:0];
                  state_d  = S_FIN;
               end else begin
                  state_d = S_MUL;
               end
            end else if (start && fast_zero) begin
               nowr_d  = 1'b1;
               state_d = S_FIN;
            end else if (start) begin
               res_hi_d = 32'd0;
               res_lo_d = abs_a;
               op_b_d   = abs_b;
               qneg_d   = is_sgn & (mdu.src_a_i[31] ^ mdu.src_b_i[31]);
               rneg_d   = is_sgn & mdu.src_a_i[31];
               nowr_d   = 1'b0;
               cnt_d    = 5'd31;
               state_d  = S_DIV;
            end else if (mt_ok) begin
               if (is_mthi) hi_d = mdu.src_a_i;
               if (is_mtlo) lo_d = mdu.src_a_i;
            end
         end
         S_MUL: begin
            if (mdu.flush_i) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
            end else begin
               // The accept cycle counts as the first latency cycle.
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  res_hi_d = prod[63:32];
                  res_lo_d = prod[31:0];
                  state_d  = S_FIN;
               end
            end
         end
         S_DIV: begin
            if (mdu.flush_i) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
            end else begin
               res_hi_d = step_rem;
               res_lo_d = step_quo;
               cnt_d    = cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  res_hi_d = rneg_q ? -step_rem : step_rem;
                  res_lo_d = qneg_q ? -step_quo : step_quo;
                  cnt_d    = 5'd0;
                  state_d  = S_FIN;
               end
            end
         end
         S_FIN: begin
            if (mdu.flush_i) begin
               state_d = S_IDLE;
            end else if (!mdu.ex_hold_i) begin
               state_d = S_IDLE;
               if (!nowr_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         op_a_q   <= 32'd0;
         op_b_q   <= 32'd0;
         sgn_q    <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         nowr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         sgn_q    <= sgn_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         nowr_q   <= nowr_d;
      end
   end

   assign mdu.stall_o = resetn & ~mdu.flush_i
                      & (start | state_q == S_MUL | state_q == S_DIV);
   assign mdu.hi_o = hi_q;
   assign mdu.lo_o = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl - directed and random checks of mdu_ctrl against an
// arithmetic reference model of HI/LO and stall length.
module tb_mdu_ctrl;
   localparam int unsigned MUL_LAT = 2;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIV   = 8'h1A;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MTLO  = 8'h13;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] m_hi, m_lo;
`ifdef MDU_DIV_ZERO_FAST_EN
   localparam bit FAST0 = 1'b1;
`else
   localparam bit FAST0 = 1'b0;
`endif

   mdu_ctrl_if mif();

   mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk),
      .resetn(resetn),
      .mdu(mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit sgn);
      longint pa, pb;
      pa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      pb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      return 64'(pa * pb);
   endfunction

   // Returns {remainder, quotient}.
   function automatic logic [63:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit sgn);
      longint q, r, sa, sb;
      if (b == 32'd0) begin
         if (sgn && a[31]) return {a, 32'd1};
         return {a, 32'hFFFF_FFFF};
      end
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold_cyc,
                         input string tag);
      int st, exp_st;
      logic [63:0] r;
      logic [31:0] o_hi, o_lo;
      o_hi = m_hi;
      o_lo = m_lo;
      if (op == OP_MULT || op == OP_MULTU) begin
         r = ref_mul(a, b, op == OP_MULT);
         m_hi = r[63:32];
         m_lo = r[31:0];
         exp_st = MUL_LAT;
      end else if (op == OP_DIV || op == OP_DIVU) begin
         if (FAST0 && b == 32'd0) begin
            exp_st = 1;
         end else begin
            r = ref_div(a, b, op == OP_DIV);
            m_hi = r[63:32];
            m_lo = r[31:0];
            exp_st = 33;
         end
      end else begin
         if (op == OP_MTHI) m_hi = a;
         if (op == OP_MTLO) m_lo = a;
         exp_st = 0;
      end
      @(negedge clk);
      mif.valid_i = 1'b1;
      mif.aluop_i = op;
      mif.src_a_i = a;
      mif.src_b_i = b;
      st = 0;
      #1;
      while (mif.stall_o && st < 60) begin
         st++;
         @(negedge clk);
         #1;
      end
      chk({tag, "_stall"}, 64'(st), 64'(exp_st));
      if (hold_cyc > 0) begin
         mif.ex_hold_i = 1'b1;
         for (int i = 0; i < hold_cyc; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_hi"}, 64'(mif.hi_o), 64'(o_hi));
            chk({tag, "_hold_lo"}, 64'(mif.lo_o), 64'(o_lo));
         end
         mif.ex_hold_i = 1'b0;
      end
      @(posedge clk);
      #1;
      mif.valid_i = 1'b0;
      chk({tag, "_hi"}, 64'(mif.hi_o), 64'(m_hi));
      chk({tag, "_lo"}, 64'(mif.lo_o), 64'(m_lo));
   endtask

   initial begin
      logic [7:0]  op;
      logic [31:0] a, b;
      m_hi = 32'd0;
      m_lo = 32'd0;
      resetn = 1'b0;
      mif.valid_i = 1'b0;
      mif.aluop_i = 8'h00;
      mif.src_a_i = 32'd0;
      mif.src_b_i = 32'd0;
      mif.flush_i = 1'b0;
      mif.ex_hold_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", 64'(mif.hi_o), 64'd0);
      chk("rst_lo", 64'(mif.lo_o), 64'd0);
      chk("rst_stall", 64'(mif.stall_o), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
      chk("multu_max_hi_const", 64'(mif.hi_o), 64'hFFFF_FFFE);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      chk("div_m7_2_lo_const", 64'(mif.lo_o), 64'hFFFF_FFFD);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, "mult_m3_5");
      chk("mult_m3_5_lo_const", 64'(mif.lo_o), 64'hFFFF_FFF1);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      chk("div_ovf_lo_const", 64'(mif.lo_o), 64'h8000_0000);

      run_op(OP_MTHI, 32'h1234, 32'd0, 0, "mthi_1234");
      run_op(OP_MTLO, 32'h1234, 32'd0, 0, "mtlo_1234");
      @(negedge clk);
      mif.valid_i = 1'b1;
      mif.aluop_i = OP_DIVU;
      mif.src_a_i = 32'd100;
      mif.src_b_i = 32'd7;
      repeat (10) @(negedge clk);
      mif.flush_i = 1'b1;
      #1;
      chk("flush_stall_now", 64'(mif.stall_o), 64'd0);
      @(posedge clk);
      #1;
      mif.flush_i = 1'b0;
      mif.valid_i = 1'b0;
      @(negedge clk);
      #1;
      chk("flush_stall_next", 64'(mif.stall_o), 64'd0);
      chk("flush_hi", 64'(mif.hi_o), 64'h1234);
      chk("flush_lo", 64'(mif.lo_o), 64'h1234);
      run_op(OP_MTHI, 32'hAA, 32'd0, 0, "mthi_aa");

      run_op(OP_DIVU, 32'd5, 32'd0, 0, "divu_5_0");
      run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, "div_m16_0");
      run_op(OP_MULT, 32'd123, 32'hFFFF_FF00, 3, "mult_hold");
      run_op(OP_DIVU, 32'd1000, 32'd9, 3, "divu_hold");

      @(negedge clk);
      mif.valid_i = 1'b1;
      mif.aluop_i = OP_DIV;
      mif.src_a_i = 32'd1000;
      mif.src_b_i = 32'd3;
      repeat (6) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rstmid_hi", 64'(mif.hi_o), 64'd0);
      chk("rstmid_lo", 64'(mif.lo_o), 64'd0);
      chk("rstmid_stall", 64'(mif.stall_o), 64'd0);
      mif.valid_i = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      resetn = 1'b1;
      run_op(OP_MULTU, 32'd7, 32'd6, 0, "post_rst");

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 5))
            0: op = OP_MULT;
            1: op = OP_MULTU;
            2: op = OP_DIV;
            3: op = OP_DIVU;
            4: op = OP_MTHI;
            default: op = OP_MTLO;
         endcase
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         run_op(op, a, b, $urandom_range(0, 1), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded `aluop` stream, sequences a multi-cycle multiply and a 32-iteration restoring divider, owns the architectural HI/LO registers and stalls the pipeline while an operation is in flight. MFHI/MFLO read `hi_o`/`lo_o`; forwarding is outside this block.

## Interface
- `MUL_LAT`, default 2: cycles `stall_o` stays high for MULT/MULTU, including the accept cycle; legal range 1–8.
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  EX holds a valid instruction.
- `aluop_i`  in  8  ALU op (`ALUOP_*` codes from defines.vh).
- `src_a_i`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- `src_b_i`  in  32  rt operand (divisor / multiplier).
- `flush_i`  in  1  kill the EX instruction this cycle.
- `ex_hold_i`  in  1  EX is held by another stall source.
- `stall_o`  out  1  MDU requests a pipeline stall.
- `hi_o`  out  32  architectural HI.
- `lo_o`  out  32  architectural LO.

## Operation
- States: IDLE, MUL, DIV, FIN.
- start = IDLE & valid_i & !flush_i & aluop_i ∈ {MULT, MULTU, DIV, DIVU}.
- IDLE -> MUL on MULT/MULTU start:
  - Latch operands and signedness.
  - Load the counter with MUL_LAT-1.
  - If MUL_LAT=1, go straight to FIN.
- MUL: counter decrements. At 0, latch the 64-bit product (signed or unsigned) into the result registers and go to FIN.
- IDLE -> DIV on DIV/DIVU start:
  - Latch |a| and |b| (signed op) or raw values (unsigned op).
  - Record the quotient sign (sa^sb) and the remainder sign (sa).
  - Load the counter with 31.
- DIV: one restoring step per cycle (shift remainder:quotient left, trial subtract, set the quotient bit). After the step at counter 0:
  - Apply sign fixes: negate the quotient if its sign is set; negate the remainder if the dividend was negative.
  - Go to FIN.
- FIN: result held as {HI=remainder/product[63:32], LO=quotient/product[31:0]}.
  - When !ex_hold_i & !flush_i: write HI/LO and go to IDLE.
  - When ex_hold_i: stay in FIN with no write.
  - When flush_i: go to IDLE with no write.
- MTHI/MTLO in IDLE with valid_i & !flush_i & !ex_hold_i: write src_a_i to HI/LO at the edge, no stall.
- flush_i in MUL or DIV: go to IDLE at the next edge. HI/LO are unchanged and the partial result is discarded.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Unsigned divide by zero (macro off) gives LO=0xFFFFFFFF, HI=dividend. Signed divide by zero gives the sign-fixed restoring result.

## Timing
- Reset: state=IDLE, hi_o=0, lo_o=0, stall_o=0, counter=0.
- stall_o = !flush_i & (start | state==MUL | state==DIV). It is combinational and drops in FIN.
- MULT/MULTU: stall_o is high for MUL_LAT cycles, then FIN. HI/LO are visible the cycle after the FIN edge, provided there is no hold.
- DIV/DIVU: stall_o is high for 33 cycles (accept cycle plus 32 steps), then FIN.
- A new start is accepted only in IDLE. The instruction that completes in FIN advances on the FIN write edge, so there are no back-to-back duplicate starts.
- resetn asserted mid-operation: outputs return immediately to reset values.

## Configuration
- `MDU_DIV_ZERO_FAST_EN` defined:
  - DIV/DIVU with src_b_i==0 goes IDLE -> FIN directly, with stall_o high for 1 cycle.
  - FIN leaves HI/LO unchanged; no write occurs.
- Undefined: divide by zero runs the full 33-cycle sequence and writes the restoring result.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MUL_LAT=2 -> stall_o high 2 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> stall_o high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. MULT -3×5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=LO=0x1234, then DIVU 100/7 with flush_i pulsed at step 10 -> HI/LO remain 0x1234 and stall_o=0 the next cycle. A following MTHI 0xAA -> HI=0xAA with no stall.
- DIVU 5/0 with macro -> 1 stall cycle, HI/LO unchanged. Without macro -> 33 stall cycles, LO=0xFFFFFFFF, HI=5.
- Two other cases:
  - ex_hold_i held 3 cycles in FIN -> no write until hold drops, single write.
  - resetn low mid-DIV -> HI=LO=0, stall_o=0 immediately.
